cs_cycle_sequencer: RTL and testbench
=====================================

# cs_cycle_sequencer

Control-store cycle sequencer. Generates the phase-coded cycle control lines CC1_n/CC2_n/CC3_n and TERM_n. Arbitrates between normal microinstruction cycles, writeable-control-store (WCS) read/write cycles and load-control-store (LCS) cycles. Drives the control-store control PAL, which decodes these lines into the write strobes and the bank and MA enables.

## Interface
Parameters:
- NORM_LAST, 3, last phase index of a normal cycle (phase d)
- WCS_LAST, 7, last phase index of a WCS cycle (phase h)
- LCS_LAST, 14, last phase index of an LCS cycle (phase o)

Ports:
- sysclk  in  1  system clock, all state on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- hold  in  1  freeze phase counter and all outputs while high
- wcs_req  in  1  WCS access request, level, held until ack
- wcs_wr  in  1  with wcs_req: 1 = write, 0 = read; sampled at grant
- lcs_req  in  1  load-control-store request, level, held until ack
- CC1_n  out  1  cycle control 1, low in phases b,c,d,e,j,k,l,m
- CC2_n  out  1  cycle control 2, low in phases e..k
- CC3_n  out  1  cycle control 3, low in phases h..o
- TERM_n  out  1  low during the last phase of the current cycle
- RWCS_n  out  1  low for the whole of a WCS cycle or an LCS cycle
- WCS_n  out  1  low for the whole of a WCS write cycle
- LCS_n  out  1  low for the whole of an LCS cycle
- wcs_ack  out  1  one-clock pulse at the last phase of a WCS cycle
- lcs_ack  out  1  one-clock pulse at the last phase of an LCS cycle
- phase  out  4  current phase index, 0 = a … 14 = o

## Operation
- Internal state:
  - 4-bit phase counter
  - 2-bit cycle type: NORM, WCS, LCS
  - latched wr flag
- All outputs are registered and decoded from the next-state values, so the outputs change coincident with the state change. There are no combinational paths from any input to any output.
- Cycle type is chosen only at phase a of each cycle (grant point):
  - Priority: lcs_req > wcs_req > NORM.
  - wcs_wr is latched at grant.
  - Requests that change mid-cycle have no effect until the next phase a.
- Phase advances by 1 each clock while hold = 0.
- When phase equals the type's LAST value:
  - TERM_n = 0 in that phase.
  - Next clock: phase = 0 and a new grant is made.
- CC decode is a pure function of phase. It is identical for all types; shorter cycles simply terminate early.
- Type-qualified strobes:
  - RWCS_n = 0 when type ∈ {WCS, LCS}.
  - WCS_n = 0 when type = WCS and wr = 1.
  - LCS_n = 0 when type = LCS.
  - All three are held for every phase of the cycle, including the TERM phase.
- Acknowledge pulses:
  - wcs_ack = 1 in the TERM phase of a WCS cycle only.
  - lcs_ack = 1 in the TERM phase of an LCS cycle only.
  - A requester deasserts its req after sampling ack. If req is still high at the next phase a, it is granted again.
- hold = 1: phase, type and every output keep their current values. This includes a TERM phase (TERM_n stays low) and any ack pulse (ack stays high for as many clocks as hold is high).
- Phase counter never exceeds LCS_LAST. An illegal phase value returns to phase 0 with type NORM.

## Timing
Reset values (asynchronous, on sys_rst_n = 0):
- phase = 0, type = NORM
- CC1_n = CC2_n = CC3_n = 1, TERM_n = 1
- RWCS_n = WCS_n = LCS_n = 1
- wcs_ack = lcs_ack = 0

After reset release:
- First rising edge: grant is evaluated at phase a.

Cycle lengths (hold = 0):
- NORM: 4 clocks, phases a..d, TERM in d.
- WCS: 8 clocks, a..h, TERM in h.
- LCS: 15 clocks, a..o, TERM in o.

Per-cycle output timing:
- Request-to-grant latency: at most one current cycle plus one clock.
- Type strobes go low on the clock that enters phase a of the granted cycle. They return high on the clock that leaves the TERM phase, unless the next cycle is of the same type; back-to-back same-type cycles produce no glitch.
- Simultaneous lcs_req and wcs_req at grant: LCS first. WCS is served at the next phase a if still requested.

Reset asserted mid-cycle:
- Immediate return to the reset values. The cycle is aborted and no ack is issued.

## Test plan
- Reset, no requests, 12 clocks:
  - TERM_n low every 4th clock (phase 3).
  - CC1_n low at phases 1–3, CC2_n/CC3_n high.
  - RWCS_n = WCS_n = LCS_n = 1.
- wcs_req = 1, wcs_wr = 1 asserted mid-NORM cycle:
  - Next phase a starts an 8-clock cycle with RWCS_n = WCS_n = 0.
  - CC2_n low at phases 4–7, CC3_n low at phase 7.
  - wcs_ack pulse at phase 7.
  - Drop req after ack: next cycle is NORM.
- lcs_req and wcs_req (wr = 0) raised together:
  - 15-clock LCS cycle with LCS_n = 0 and lcs_ack at phase 14.
  - Then 8-clock WCS read cycle with RWCS_n = 0, WCS_n = 1.
- hold = 1 for 3 clocks at phase 7 of a WCS cycle:
  - phase stays 7, TERM_n stays 0, wcs_ack stays 1 for 3 clocks.
  - Cycle resumes and ends normally.
- sys_rst_n pulsed low at phase 9 of an LCS cycle:
  - All outputs return to reset values immediately, no lcs_ack.
  - After release, a new LCS cycle starts at phase 0 if lcs_req is still high.
- Full CC decode sweep over an LCS cycle: CC1_n/CC2_n/CC3_n match the letter sets a..o exactly, with phase 4 (e) having all of CC1_n = CC2_n = 0.

Source files
------------

// File: rtl/cs_cycle_sequencer.sv
// Control-store cycle sequencer: phase counter plus cycle-type arbiter that
// generates the phase-coded CC1_n/CC2_n/CC3_n/TERM_n lines and the WCS/LCS strobes.
module cs_cycle_sequencer #(
   parameter int NORM_LAST = 3,
   parameter int WCS_LAST  = 7,
   parameter int LCS_LAST  = 14
) (
   input  logic       sysclk,
   input  logic       sys_rst_n,
   input  logic       hold,
   input  logic       wcs_req,
   input  logic       wcs_wr,
   input  logic       lcs_req,
   output logic       CC1_n,
   output logic       CC2_n,
   output logic       CC3_n,
   output logic       TERM_n,
   output logic       RWCS_n,
   output logic       WCS_n,
   output logic       LCS_n,
   output logic       wcs_ack,
   output logic       lcs_ack,
   output logic [3:0] phase
);

   typedef enum logic [1:0] {
      CYC_NORM = 2'd0,
      CYC_WCS  = 2'd1,
      CYC_LCS  = 2'd2
   } cyc_t;

   localparam logic [3:0] NORM_L = NORM_LAST[3:0];
   localparam logic [3:0] WCS_L  = WCS_LAST[3:0];
   localparam logic [3:0] LCS_L  = LCS_LAST[3:0];

   logic [3:0] phase_reg, phase_next;
   cyc_t       type_reg, type_next;
   logic       wr_reg, wr_next;
   logic       start_reg, start_next;
   logic       grant;

   logic cc1_n_next, cc2_n_next, cc3_n_next, term_n_next;
   logic rwcs_n_next, wcs_n_next, lcs_n_next;
   logic wcs_ack_next, lcs_ack_next;
   logic is_last_next;

   function automatic logic [3:0] last_of(input cyc_t t);
      case (t)
         CYC_WCS: last_of = WCS_L;
         CYC_LCS: last_of = LCS_L;
         default: last_of = NORM_L;
      endcase
   endfunction

   // start_reg marks the post-reset phase a whose grant has not been made yet;
   // the first unheld clock after reset makes that grant.
   always_comb begin
      phase_next = phase_reg;
      type_next  = type_reg;
      wr_next    = wr_reg;
      start_next = start_reg;
      grant      = 1'b0;
      if (!hold) begin
         start_next = 1'b0;
         if (start_reg) begin
            grant = 1'b1;
         end else if (phase_reg > LCS_L) begin
            phase_next = 4'd0;
            type_next  = CYC_NORM;
            wr_next    = 1'b0;
         end else if (phase_reg == last_of(type_reg)) begin
            grant = 1'b1;
         end else begin
            phase_next = phase_reg + 4'd1;
         end
         if (grant) begin
            phase_next = 4'd0;
            if (lcs_req) begin
               type_next = CYC_LCS;
               wr_next   = 1'b0;
            end else if (wcs_req) begin
               type_next = CYC_WCS;
               wr_next   = wcs_wr;
            end else begin
               type_next = CYC_NORM;
               wr_next   = 1'b0;
            end
         end
      end
   end

   // Output decode works on next-state values so the registered outputs
   // change on the same edge as the state they describe.
   always_comb begin
      is_last_next = (phase_next == last_of(type_next));
      cc1_n_next   = ~(((phase_next >= 4'd1) && (phase_next <= 4'd4)) ||
                       ((phase_next >= 4'd9) && (phase_next <= 4'd12)));
      cc2_n_next   = ~((phase_next >= 4'd4) && (phase_next <= 4'd10));
      cc3_n_next   = ~((phase_next >= 4'd7) && (phase_next <= 4'd14));
      term_n_next  = ~is_last_next;
      rwcs_n_next  = ~((type_next == CYC_WCS) || (type_next == CYC_LCS));
      wcs_n_next   = ~((type_next == CYC_WCS) && wr_next);
      lcs_n_next   = ~(type_next == CYC_LCS);
      wcs_ack_next = is_last_next && (type_next == CYC_WCS);
      lcs_ack_next = is_last_next && (type_next == CYC_LCS);
      if (start_next) begin
         // Reset-equivalent state: hold keeps the outputs idle before the first grant.
         cc1_n_next   = 1'b1;
         cc2_n_next   = 1'b1;
         cc3_n_next   = 1'b1;
         term_n_next  = 1'b1;
         rwcs_n_next  = 1'b1;
         wcs_n_next   = 1'b1;
         lcs_n_next   = 1'b1;
         wcs_ack_next = 1'b0;
         lcs_ack_next = 1'b0;
      end
   end

   always_ff @(posedge sysclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         phase_reg <= 4'd0;
         type_reg  <= CYC_NORM;
         wr_reg    <= 1'b0;
         start_reg <= 1'b1;
         CC1_n     <= 1'b1;
         CC2_n     <= 1'b1;
         CC3_n     <= 1'b1;
         TERM_n    <= 1'b1;
         RWCS_n    <= 1'b1;
         WCS_n     <= 1'b1;
         LCS_n     <= 1'b1;
         wcs_ack   <= 1'b0;
         lcs_ack   <= 1'b0;
      end else begin
         phase_reg <= phase_next;
         type_reg  <= type_next;
         wr_reg    <= wr_next;
         start_reg <= start_next;
         CC1_n     <= cc1_n_next;
         CC2_n     <= cc2_n_next;
         CC3_n     <= cc3_n_next;
         TERM_n    <= term_n_next;
         RWCS_n    <= rwcs_n_next;
         WCS_n     <= wcs_n_next;
         LCS_n     <= lcs_n_next;
         wcs_ack   <= wcs_ack_next;
         lcs_ack   <= lcs_ack_next;
      end
   end

   assign phase = phase_reg;

endmodule

// File: tb/tb_cs_cycle_sequencer.sv
// Directed bench for cs_cycle_sequencer: NORM, WCS write/read, LCS priority,
// hold at a TERM phase and reset in the middle of an LCS cycle.
module tb_cs_cycle_sequencer;

   logic       sysclk = 1'b0;
   logic       sys_rst_n;
   logic       hold;
   logic       wcs_req;
   logic       wcs_wr;
   logic       lcs_req;
   logic       CC1_n, CC2_n, CC3_n, TERM_n;
   logic       RWCS_n, WCS_n, LCS_n;
   logic       wcs_ack, lcs_ack;
   logic [3:0] phase;

   int n_checks = 0;
   int n_errors = 0;

   always #5 sysclk = ~sysclk;

   cs_cycle_sequencer dut (
      .sysclk    (sysclk),
      .sys_rst_n (sys_rst_n),
      .hold      (hold),
      .wcs_req   (wcs_req),
      .wcs_wr    (wcs_wr),
      .lcs_req   (lcs_req),
      .CC1_n     (CC1_n),
      .CC2_n     (CC2_n),
      .CC3_n     (CC3_n),
      .TERM_n    (TERM_n),
      .RWCS_n    (RWCS_n),
      .WCS_n     (WCS_n),
      .LCS_n     (LCS_n),
      .wcs_ack   (wcs_ack),
      .lcs_ack   (lcs_ack),
      .phase     (phase)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".phase"}, int'(phase), 0);
      check({tag, ".CC1_n"}, int'(CC1_n), 1);
      check({tag, ".CC2_n"}, int'(CC2_n), 1);
      check({tag, ".CC3_n"}, int'(CC3_n), 1);
      check({tag, ".TERM_n"}, int'(TERM_n), 1);
      check({tag, ".RWCS_n"}, int'(RWCS_n), 1);
      check({tag, ".WCS_n"}, int'(WCS_n), 1);
      check({tag, ".LCS_n"}, int'(LCS_n), 1);
      check({tag, ".wcs_ack"}, int'(wcs_ack), 0);
      check({tag, ".lcs_ack"}, int'(lcs_ack), 0);
   endtask

   // Expected CC levels come from the phase letter sets: CC1 low b-e,j-m,
   // CC2 low e-k, CC3 low h-o.
   task automatic cyc_check(input string tag, input int p, input int last,
                            input int e_rwcs, input int e_wcs, input int e_lcs,
                            input int is_wcs, input int is_lcs);
      string t;
      int    e_cc1, e_cc2, e_cc3, at_last;
      t       = $sformatf("%s@%0d", tag, p);
      e_cc1   = (((p >= 1) && (p <= 4)) || ((p >= 9) && (p <= 12))) ? 0 : 1;
      e_cc2   = ((p >= 4) && (p <= 10)) ? 0 : 1;
      e_cc3   = ((p >= 7) && (p <= 14)) ? 0 : 1;
      at_last = (p == last) ? 1 : 0;
      check({t, ".phase"}, int'(phase), p);
      check({t, ".CC1_n"}, int'(CC1_n), e_cc1);
      check({t, ".CC2_n"}, int'(CC2_n), e_cc2);
      check({t, ".CC3_n"}, int'(CC3_n), e_cc3);
      check({t, ".TERM_n"}, int'(TERM_n), 1 - at_last);
      check({t, ".RWCS_n"}, int'(RWCS_n), e_rwcs);
      check({t, ".WCS_n"}, int'(WCS_n), e_wcs);
      check({t, ".LCS_n"}, int'(LCS_n), e_lcs);
      check({t, ".wcs_ack"}, int'(wcs_ack), is_wcs * at_last);
      check({t, ".lcs_ack"}, int'(lcs_ack), is_lcs * at_last);
   endtask

   initial begin
      hold      = 1'b0;
      wcs_req   = 1'b0;
      wcs_wr    = 1'b0;
      lcs_req   = 1'b0;
      sys_rst_n = 1'b1;
      #2 sys_rst_n = 1'b0;
      #1 check_reset("reset");
      #5 sys_rst_n = 1'b1;

      // Idle NORM cycles: a..d repeating
      for (int k = 0; k < 12; k++) begin
         tick();
         cyc_check("norm", k % 4, 3, 1, 1, 1, 0, 0);
      end
      tick();
      cyc_check("norm", 0, 3, 1, 1, 1, 0, 0);

      // WCS write raised after the grant point: waits for the next phase a
      wcs_req = 1'b1;
      wcs_wr  = 1'b1;
      for (int p = 1; p < 4; p++) begin
         tick();
         cyc_check("norm_pend", p, 3, 1, 1, 1, 0, 0);
      end
      for (int p = 0; p < 8; p++) begin
         tick();
         cyc_check("wcs_wr", p, 7, 0, 0, 1, 1, 0);
      end
      wcs_req = 1'b0;
      tick();
      cyc_check("after_wcs", 0, 3, 1, 1, 1, 0, 0);

      // LCS and WCS read together: LCS first, then WCS read
      lcs_req = 1'b1;
      wcs_req = 1'b1;
      wcs_wr  = 1'b0;
      for (int p = 1; p < 4; p++) begin
         tick();
         cyc_check("norm_pend2", p, 3, 1, 1, 1, 0, 0);
      end
      for (int p = 0; p < 15; p++) begin
         tick();
         cyc_check("lcs", p, 14, 0, 1, 0, 0, 1);
      end
      lcs_req = 1'b0;
      for (int p = 0; p < 8; p++) begin
         tick();
         cyc_check("wcs_rd", p, 7, 0, 1, 1, 1, 0);
      end

      // Hold at the TERM phase keeps TERM_n low and the ack high
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         cyc_check("hold", 7, 7, 0, 1, 1, 1, 0);
      end
      hold    = 1'b0;
      wcs_req = 1'b0;
      tick();
      cyc_check("post_hold", 0, 3, 1, 1, 1, 0, 0);

      // Reset in the middle of an LCS cycle
      lcs_req = 1'b1;
      for (int p = 1; p < 4; p++) begin
         tick();
         cyc_check("norm_pend3", p, 3, 1, 1, 1, 0, 0);
      end
      for (int p = 0; p < 10; p++) begin
         tick();
         cyc_check("lcs_pre_rst", p, 14, 0, 1, 0, 0, 1);
      end
      sys_rst_n = 1'b0;
      #1 check_reset("reset_mid");
      #2 sys_rst_n = 1'b1;
      tick();
      cyc_check("lcs_restart", 0, 14, 0, 1, 0, 0, 1);
      tick();
      cyc_check("lcs_restart", 1, 14, 0, 1, 0, 0, 1);
      lcs_req = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
